// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the serial deserializer:
//   deser_state_e : FSM state encoding (S_DATA collects data bits, S_PAR waits
//                   for the trailing parity bit when parity is built in)
//   DEF_WIDTH     : default number of data bits per frame
//   cnt_width()   : width of the bit counter for a given frame width
// -----------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } deser_state_e;

    localparam int DEF_WIDTH = 8;

    // clog2 of the frame width, never less than one bit so the counter
    // always has a legal declaration.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// -----------------------------------------------------------------------------
// deser_shift_reg
// WIDTH-bit MSB-first shift register. Each enabled cycle shifts the register
// left by one and inserts din at bit 0, so after WIDTH shifts the first bit
// taken sits in q[WIDTH-1].
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset, clears the register
//   shift_en : shift in din this cycle
//   din      : serial input bit
//   q        : current register contents
// -----------------------------------------------------------------------------
module deser_shift_reg
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (shift_en) begin
            q_reg <= {q_reg[WIDTH-2:0], din};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
// Collects serial bits (MSB first) into WIDTH-bit words and presents them on
// a single-entry valid/ready output buffer. The serial side has no
// back-pressure: a word completed while the buffer is still full is dropped
// and the sticky overflow flag is raised.
//
// Optional feature: define DESER_PARITY_EN to append one even-parity bit to
// every frame and add the parity_err output.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   din        : serial data bit
//   din_valid  : din is sampled only when this is 1
//   dout       : assembled word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout when dout_valid is also 1
//   overflow   : sticky, set when a completed word is dropped
//   parity_err : (DESER_PARITY_EN only) word in dout failed its parity check
// -----------------------------------------------------------------------------
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
`ifdef DESER_PARITY_EN
    output logic             overflow,
    output logic             parity_err
`else
    output logic             overflow
`endif
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    deser_state_e     state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    // Frame completed on the previous edge; the word is moved into the
    // output buffer on the following edge, once the shift register holds it.
    logic             done_reg, done_next;
    logic             shift_en;
    logic [WIDTH-1:0] shift_q;

    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             overflow_reg;

`ifdef DESER_PARITY_EN
    logic             perr_pend_reg, perr_pend_next;
    logic             parity_err_reg;
`endif

    deser_shift_reg #(
        .WIDTH    (WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (din),
        .q        (shift_q)
    );

    // ------------------------------------------------------------------
    // Bit counter / FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_DATA;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_pend_reg <= 1'b0;
        end else begin
            perr_pend_reg <= perr_pend_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        shift_en   = 1'b0;
`ifdef DESER_PARITY_EN
        perr_pend_next = perr_pend_reg;
`endif
        if (din_valid) begin
            case (state_reg)
                S_DATA: begin
                    shift_en = 1'b1;
                    if (cnt_reg == LAST) begin
`ifdef DESER_PARITY_EN
                        // Counter parks on the last data bit until the
                        // parity bit arrives.
                        state_next = S_PAR;
`else
                        cnt_next  = '0;
                        done_next = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`ifdef DESER_PARITY_EN
                S_PAR: begin
                    // Data bits are complete in the shift register; din is
                    // the parity bit. Even parity: total XOR must be zero.
                    state_next     = S_DATA;
                    cnt_next       = '0;
                    done_next      = 1'b1;
                    perr_pend_next = (^shift_q) ^ din;
                end
`endif
                default: begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else if (done_reg) begin
            // A handshake on this same edge frees the entry for the new word.
            if (!dout_valid_reg || dout_ready) begin
                dout_reg       <= shift_q;
                dout_valid_reg <= 1'b1;
`ifdef DESER_PARITY_EN
                parity_err_reg <= perr_pend_reg;
`endif
            end else begin
                overflow_reg <= 1'b1;
            end
        end else if (dout_valid_reg && dout_ready) begin
            dout_valid_reg <= 1'b0;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign overflow   = overflow_reg;
`ifdef DESER_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
// Directed scenarios followed by a randomized stream, all checked every cycle
// against a word-level reference model (bits accumulated arithmetically,
// completed words handed to a one-entry buffer one edge later).
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overflow;
`ifdef DESER_PARITY_EN
    logic             parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_acc;
    int               m_n;
    bit               m_pend;
    logic [WIDTH-1:0] m_pword;
    logic             m_pperr;
    logic             m_v;
    logic [WIDTH-1:0] m_d;
    logic             m_ovf;
    logic             m_perr;

    // Observation helpers for directed scenarios
    int               vcount;
    logic [WIDTH-1:0] vword;

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef DESER_PARITY_EN
        .overflow   (overflow),
        .parity_err (parity_err)
`else
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_n = 0; m_pend = 0; m_pword = '0; m_pperr = 0;
        m_v = 0; m_d = '0; m_ovf = 0; m_perr = 0;
    endtask

    // Advance the model across one rising edge given the inputs present.
    task automatic model_edge(input logic v, input logic b, input logic r);
        if (m_pend) begin
            if (!m_v || r) begin
                m_d = m_pword; m_v = 1'b1; m_perr = m_pperr;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_v && r) begin
            m_v = 1'b0;
        end
        m_pend = 0;
        if (v) begin
            if (m_n < WIDTH) begin
                m_acc = WIDTH'((m_acc * 2) + b);
                m_n++;
`ifndef DESER_PARITY_EN
                if (m_n == WIDTH) begin
                    m_pend = 1; m_pword = m_acc; m_pperr = 0; m_n = 0;
                end
`endif
            end else begin
                m_pend = 1; m_pword = m_acc; m_pperr = (^m_acc) ^ b; m_n = 0;
            end
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".dout_valid"}, 32'(dout_valid), 32'(m_v));
        chk({where, ".dout"},       32'(dout),       32'(m_d));
        chk({where, ".overflow"},   32'(overflow),   32'(m_ovf));
`ifdef DESER_PARITY_EN
        chk({where, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
    endtask

    // One clock cycle: drive at negedge, advance model, compare at next negedge.
    task automatic step(input logic v, input logic b, input logic r);
        din_valid = v; din = b; dout_ready = r;
        model_edge(v, b, r);
        @(posedge clk);
        @(negedge clk);
        check_outputs("step");
        if (dout_valid === 1'b1) begin
            vcount++;
            vword = dout;
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic pbit,
                              input int gaps, input logic r);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b1, w[i], r);
            for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom), r);
        end
`ifdef DESER_PARITY_EN
        step(1'b1, pbit, r);
`else
        if (pbit) begin end
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        din_valid = 1'($urandom); din = 1'($urandom); dout_ready = 1'($urandom);
        #1;
        model_reset();
        check_outputs("reset_async");
        repeat (cycles) @(negedge clk);
        check_outputs("reset_hold");
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(2);

        // Mid-stream reset, then 8'hA5
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        do_reset(2);
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("a5_not_yet_valid", 32'(dout_valid), 32'd0);
        step(0, 0, 0);
        $display("txn a5: dout=%h valid=%0d", dout, dout_valid);
        chk("a5_valid", 32'(dout_valid), 32'd1);
        chk("a5_dout", 32'(dout), 32'hA5);
        step(0, 0, 1);   // drain
        chk("a5_drained", 32'(dout_valid), 32'd0);

        // 8'h3C with gaps, ready held high: valid exactly one cycle
        vcount = 0; vword = '0;
        send_frame(8'h3C, 1'b0, 2, 1'b1);
        repeat (4) step(0, 0, 1);
        $display("txn 3c: word=%h valid_cycles=%0d", vword, vcount);
        chk("3c_valid_cycles", 32'(vcount), 32'd1);
        chk("3c_dout", 32'(vword), 32'h3C);

        // Overflow: 8'h11 held, 8'h22 dropped
        send_frame(8'h11, 1'b0, 0, 1'b0);
        step(0, 0, 0);
        send_frame(8'h22, 1'b0, 1, 1'b0);
        repeat (2) step(0, 0, 0);
        $display("txn ovf: dout=%h overflow=%0d", dout, overflow);
        chk("ovf_dout_kept", 32'(dout), 32'h11);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(0, 0, 1);
        chk("ovf_handshake_clears", 32'(dout_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous handshake and completion
        do_reset(2);
        send_frame(8'h0F, 1'b0, 0, 1'b0);
        step(0, 0, 0);
        send_frame(8'hF0, 1'b0, 0, 1'b0);
        step(0, 0, 1);
        $display("txn simul: dout=%h valid=%0d overflow=%0d", dout, dout_valid, overflow);
        chk("simul_dout", 32'(dout), 32'hF0);
        chk("simul_valid", 32'(dout_valid), 32'd1);
        chk("simul_no_ovf", 32'(overflow), 32'd0);
        step(0, 0, 1);

        // Reset after 4 bits of 8'hFF, then 8'h81
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        do_reset(1);
        send_frame(8'h81, 1'b0, 0, 1'b0);
        step(0, 0, 0);
        $display("txn 81: dout=%h", dout);
        chk("no_stale_dout", 32'(dout), 32'h81);
        step(0, 0, 1);

`ifdef DESER_PARITY_EN
        send_frame(8'h03, 1'b0, 0, 1'b1);
        step(0, 0, 0);
        $display("txn par03: dout=%h perr=%0d", dout, parity_err);
        chk("par03_ok", 32'(parity_err), 32'd0);
        step(0, 0, 1);
        send_frame(8'h07, 1'b0, 0, 1'b0);
        step(0, 0, 0);
        $display("txn par07: dout=%h perr=%0d", dout, parity_err);
        chk("par07_err", 32'(parity_err), 32'd1);
        chk("par07_dout", 32'(dout), 32'h07);
        step(0, 0, 1);
`endif

        // Randomized stream, checked every cycle against the model
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset(1 + int'($urandom_range(0, 2)));
            step(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        $display("txn random: dout=%h valid=%0d overflow=%0d", dout, dout_valid, overflow);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per frame (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port din, input, 1 bit: serial data bit, driven by the upstream d_ff q output.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din is sampled only on cycles where this is 1.
REQ-006 The block SHALL have port dout, output, WIDTH bits: the assembled parallel word.
REQ-007 The block SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-008 The block SHALL have port dout_ready, input, 1 bit: the consumer accepts dout when dout_valid and dout_ready are both 1.
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a completed word is dropped.
REQ-010 When PARITY_EN is defined, the block SHALL have port parity_err, output, 1 bit: the word in dout failed its parity check.

Function
REQ-011 Serial bits SHALL be shifted in MSB-first: the first sampled bit lands in dout[WIDTH-1].
REQ-012 A bit counter SHALL count 0..WIDTH-1, increment only on din_valid=1, and wrap to 0 after the last data bit (last parity bit when PARITY_EN is defined).
REQ-013 The FSM SHALL have states S_DATA and S_PAR; S_PAR exists only when PARITY_EN is defined.
REQ-014 The FSM SHALL transition S_DATA->S_PAR on the WIDTH-th data bit when PARITY_EN is defined, otherwise S_DATA->S_DATA with frame completion.
REQ-015 The FSM SHALL transition S_PAR->S_DATA on the next din_valid=1, which completes the frame.
REQ-016 Latency: dout_valid SHALL rise on the clock edge after the edge that samples the frame's final bit; cycles with din_valid=0 SHALL add no effect other than delay.
REQ-017 Output buffer: a single entry; dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-018 On handshake (dout_valid=1, dout_ready=1) with no completing frame, dout_valid SHALL clear on the next edge.
REQ-019 Simultaneous handshake and frame completion: the new word SHALL load, dout_valid SHALL stay 1, and overflow SHALL remain unchanged.
REQ-020 Frame completion while dout_valid=1 and dout_ready=0: the new word SHALL be discarded, dout SHALL be unchanged, and overflow SHALL set to 1 and stay 1 until reset.
REQ-021 Bit collection SHALL continue regardless of dout_ready; the serial side has no back-pressure.
REQ-022 dout_ready while dout_valid=0 SHALL have no effect.

Reset
REQ-023 rst=0 SHALL immediately force dout=0, dout_valid=0, overflow=0, parity_err=0, bit counter=0, and FSM=S_DATA, independent of clk.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first din_valid after deassertion SHALL be treated as bit WIDTH-1.

Configuration
REQ-025 Macro DESER_PARITY_EN: when defined, each frame SHALL be WIDTH data bits followed by one even-parity bit.
REQ-026 With DESER_PARITY_EN defined, parity_err SHALL be loaded alongside dout: 1 if XOR of the data bits and the parity bit is 1. A word with bad parity SHALL still be delivered.
REQ-027 Without DESER_PARITY_EN, frames SHALL be WIDTH bits, and S_PAR and parity_err SHALL not exist.

Structure
REQ-028 Package deser_pkg SHALL hold the FSM state enum (S_DATA, S_PAR), DEF_WIDTH=8, and the counter-width function (clog2 of WIDTH).
REQ-029 One sub-module, deser_shift_reg, SHALL hold the WIDTH-bit MSB-first shift register with a shift enable; the top level SHALL hold the FSM, counter and output buffer.

Verification
REQ-030 Scenario: rst=0 for 2 cycles mid-stream -> all outputs 0; next 8 valid bits 1,0,1,0,0,1,0,1 -> dout=8'hA5, dout_valid=1 one cycle after the 8th bit.
REQ-031 Scenario: bits of 8'h3C with din_valid=0 gaps between bits, dout_ready=1 -> dout=8'h3C; dout_valid high exactly 1 cycle.
REQ-032 Scenario: 8'h11 held with dout_ready=0, then 8'h22 fully sent -> dout stays 8'h11, overflow=1; later handshake -> dout_valid=0, overflow stays 1.
REQ-033 Scenario: dout_ready pulsed on the same edge the 8th bit of 8'hF0 completes while 8'h0F is held -> dout=8'hF0, dout_valid=1, overflow=0.
REQ-034 Scenario: reset after 4 bits of 8'hFF, then 8'h81 sent -> dout=8'h81 with no stale bits.
REQ-035 Scenario (DESER_PARITY_EN): 8'h03 with parity bit 0 -> parity_err=0; 8'h07 with parity bit 0 -> parity_err=1 and dout=8'h07.
